// File: rtl/cic_interp_pkg.sv
// Shared CIC helpers: legal interpolation factors, rate decode, growth width
// and the round-then-shift normaliser also used by the decimator.
package cic_pkg;

  localparam logic [4:0] R_X1  = 5'd1;
  localparam logic [4:0] R_X2  = 5'd2;
  localparam logic [4:0] R_X4  = 5'd4;
  localparam logic [4:0] R_X8  = 5'd8;
  localparam logic [4:0] R_X16 = 5'd16;

  // Illegal factors decode as R=1.
  function automatic logic [2:0] log2r(input logic [4:0] r);
    case (r)
      R_X1:    return 3'd0;
      R_X2:    return 3'd1;
      R_X4:    return 3'd2;
      R_X8:    return 3'd3;
      R_X16:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int unsigned cic_width(input int unsigned dw, input int unsigned q);
    return dw + 4 * q;
  endfunction

  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input logic [4:0] s);
    logic signed [63:0] rnd;
    if (s == '0) return v;
    rnd = 64'sd1 <<< (s - 5'd1);
    return (v + rnd) >>> s;
  endfunction

endpackage

// File: rtl/cic_interp_stage.sv
// One comb + integrator pair of the CIC interpolator; both wrap modulo 2^W.
module cic_interp_stage
  import cic_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         comb_en,
  input  logic         int_en,
  input  logic [W-1:0] comb_in,
  input  logic [W-1:0] int_in,
  output logic [W-1:0] comb_out,
  output logic [W-1:0] int_out
);

  logic [W-1:0] dly;
  logic [W-1:0] acc;

  assign comb_out = comb_in - dly;
  assign int_out  = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly <= '0;
      acc <= '0;
    end else begin
      if (comb_en) dly <= comb_in;
      if (int_en)  acc <= acc + int_in;
    end
  end

endmodule

// File: rtl/cic_interp.sv
// CIC interpolator, R in {1,2,4,8,16}, unity DC gain output at clk/TICK_DIV.
// Define CIC_INTERP_SAT_EN to saturate the normalised output instead of wrapping.
module cic_interp
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned Q          = 1,
  parameter int unsigned TICK_DIV   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            R,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  underrun
);

  localparam int unsigned     W        = cic_width(DATA_WIDTH, Q);
  localparam int unsigned     CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]         cnt;
  logic [3:0]            phase;
  logic [3:0]            phase_last;
  logic [2:0]            lg_l;
  logic [2:0]            lg_in;
  logic                  tick;
  logic                  slot;
  logic [DATA_WIDTH-1:0] x;
  logic [W-1:0]          x_ext;
  logic [W-1:0]          u;
  logic [W-1:0]          i_last;
  logic signed [63:0]    i_ext64;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] y_next;

  assign tick       = rst_n & (cnt == CNT_LAST);
  assign slot       = tick & (phase == '0);
  assign in_ready   = slot;
  assign underrun   = slot & ~in_valid;
  assign lg_in      = log2r(R);
  assign phase_last = 4'((5'd1 << lg_l) - 5'd1);

  assign x     = in_valid ? in_data : '0;
  assign x_ext = {{(W - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};

  // R is sampled only on an input slot, so a rate change never splits a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= '0;
      lg_l  <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (slot) begin
        lg_l  <= lg_in;
        phase <= (lg_in == '0) ? 4'd0 : 4'd1;
      end else if (tick) begin
        phase <= (phase == phase_last) ? 4'd0 : phase + 4'd1;
      end
    end
  end

  for (genvar k = 0; k < Q; k++) begin : g_stage
    logic [W-1:0] c_in;
    logic [W-1:0] i_in;
    logic [W-1:0] c_out;
    logic [W-1:0] i_out;

    if (k == 0) begin : g_first
      assign c_in = x_ext;
      assign i_in = u;
    end else begin : g_next
      assign c_in = g_stage[k-1].c_out;
      assign i_in = g_stage[k-1].i_out;
    end

    cic_interp_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .comb_en  (slot),
      .int_en   (tick),
      .comb_in  (c_in),
      .int_in   (i_in),
      .comb_out (c_out),
      .int_out  (i_out)
    );
  end

  assign u       = slot ? g_stage[Q-1].c_out : '0;
  assign i_last  = g_stage[Q-1].i_out;
  assign i_ext64 = {{(64 - W){i_last[W-1]}}, i_last};
  assign shamt   = 5'((Q - 1) * lg_l);

`ifdef CIC_INTERP_SAT_EN
  localparam logic signed [63:0] Y_MAX = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] Y_MIN = -(64'sd1 <<< (DATA_WIDTH - 1));

  logic signed [63:0] y_full;
  assign y_full = round_shift(i_ext64, shamt);

  always_comb begin
    y_next = DATA_WIDTH'(y_full);
    if (y_full > Y_MAX)      y_next = DATA_WIDTH'(Y_MAX);
    else if (y_full < Y_MIN) y_next = DATA_WIDTH'(Y_MIN);
  end
`else
  assign y_next = DATA_WIDTH'(round_shift(i_ext64, shamt));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= tick;
      if (tick) out_data <= y_next;
    end
  end

endmodule
